// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants for the IF->ID instruction queue: MIPS field positions, immediate-extension codes, nop word.
// The imm_extend helper serves the optional IFQ_IMM_EXT_EN build.
package instr_fetch_queue_pkg;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNC_HI  = 5;
    localparam int FUNC_LO  = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JIDX_HI  = 25;
    localparam int JIDX_LO  = 0;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // sll $0,$0,0 -- what ID sees while the queue is empty
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] imm_extend(input logic [1:0] ext_op, input logic [15:0] imm16);
        logic [31:0] r;
        case (ext_op)
            EXT_ZERO: r = {16'h0000, imm16};
            EXT_SIGN: r = {{16{imm16[15]}}, imm16};
            EXT_LUI:  r = {imm16, 16'h0000};
            default:  r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ifq_field_split.sv
// Purely combinational split of a MIPS instruction word into decoder fields.
// With IFQ_IMM_EXT_EN defined it also produces the extended immediate selected by ext_op.
module ifq_field_split
    import instr_fetch_queue_pkg::*;
(
    input  logic [31:0] word,
`ifdef IFQ_IMM_EXT_EN
    input  logic [1:0]  ext_op,
    output logic [31:0] imm_ext,
`endif
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] jidx26
);

    assign op     = word[OP_HI:OP_LO];
    assign func   = word[FUNC_HI:FUNC_LO];
    assign rs     = word[RS_HI:RS_LO];
    assign rt     = word[RT_HI:RT_LO];
    assign rd     = word[RD_HI:RD_LO];
    assign shamt  = word[SHAMT_HI:SHAMT_LO];
    assign imm16  = word[IMM_HI:IMM_LO];
    assign jidx26 = word[JIDX_HI:JIDX_LO];

`ifdef IFQ_IMM_EXT_EN
    assign imm_ext = imm_extend(ext_op, word[IMM_HI:IMM_LO]);
`endif

endmodule

// File: rtl/instr_fetch_queue.sv
// DEPTH-entry {pc, instr} queue between IF and ID with flush and head-field decode.
// Define IFQ_IMM_EXT_EN to add the ext_op input and imm_ext output.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int PC_W  = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       op,
    output logic [5:0]       func,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [15:0]      imm16,
    output logic [25:0]      jidx26,
`ifdef IFQ_IMM_EXT_EN
    input  logic [1:0]       ext_op,
    output logic [31:0]      imm_ext,
`endif
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      instr_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem    [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [31:0]      head_word;

    // Handshake: a beat transfers on a side when its valid and ready are both high at the
    // rising edge; ready/valid outputs depend only on registered count, never on the partner.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers/count define what is live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
        end
    end

    assign head_word = out_valid ? instr_mem[rd_ptr_q] : NOP_WORD;
    assign out_instr = head_word;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;
    assign count     = count_q;

    ifq_field_split u_split (
        .word   (head_word),
`ifdef IFQ_IMM_EXT_EN
        .ext_op (ext_op),
        .imm_ext(imm_ext),
`endif
        .op     (op),
        .func   (func),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .imm16  (imm16),
        .jidx26 (jidx26)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue (DEPTH=4): scoreboard queue of {pc, instr} models the FIFO contents.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = '0;
    logic [PC_W-1:0]  in_pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic [PC_W-1:0]  out_pc;
    logic [5:0]       op, func;
    logic [4:0]       rs, rt, rd, shamt;
    logic [15:0]      imm16;
    logic [25:0]      jidx26;
    logic [CNT_W-1:0] count;
`ifdef IFQ_IMM_EXT_EN
    logic [1:0]       ext_op = 2'b00;
    logic [31:0]      imm_ext;
`endif

    logic [63:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .op       (op),
        .func     (func),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .imm16    (imm16),
        .jidx26   (jidx26),
`ifdef IFQ_IMM_EXT_EN
        .ext_op   (ext_op),
        .imm_ext  (imm_ext),
`endif
        .count    (count)
    );

    // Drive one cycle of stimulus and advance the scoreboard by what the edge should do.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        logic do_push, do_pop;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        do_push = v && (exp_q.size() < DEPTH);
        do_pop  = rdy && (exp_q.size() != 0);
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({pc, ins});
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h1234_5678, 32'h100, 1'b0, 1'b0);
        drive(1'b1, 32'h2345_6789, 32'h104, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        n_total++;
        if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++;
        if (op !== 6'h00) $display("FAIL reset_op: got %h want 00", op); else n_pass++;
        n_total++;
        if (out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h want 0", out_instr); else n_pass++;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_push();
        drive(1'b1, 32'h8C88_0004, 32'h3000, 1'b0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL push_out_valid: got %b want 1", out_valid); else n_pass++;
        n_total++;
        if (op !== 6'h23) $display("FAIL push_op: got %h want 23", op); else n_pass++;
        n_total++;
        if (rs !== 5'd4) $display("FAIL push_rs: got %0d want 4", rs); else n_pass++;
        n_total++;
        if (rt !== 5'd8) $display("FAIL push_rt: got %0d want 8", rt); else n_pass++;
        n_total++;
        if (imm16 !== 16'h0004) $display("FAIL push_imm16: got %h want 0004", imm16); else n_pass++;
        n_total++;
        if (out_pc !== 32'h3000) $display("FAIL push_out_pc: got %h want 3000", out_pc); else n_pass++;
        n_total++;
        if (count !== CNT_W'(1)) $display("FAIL push_count: got %0d want 1", count); else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_total++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0)
            $display("FAIL empty_outputs: valid=%b instr=%h pc=%h want 0/0/0", out_valid, out_instr, out_pc);
        else n_pass++;
        n_total++;
        if ({rs, rt, rd, shamt, func, jidx26} !== '0)
            $display("FAIL empty_fields: rs=%0d rt=%0d rd=%0d shamt=%0d func=%0d jidx=%h want 0",
                     rs, rt, rd, shamt, func, jidx26);
        else n_pass++;
    endtask

    task automatic test_fill_and_drain();
        logic [31:0] w;
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, $urandom, 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
        n_total++;
        if (count !== CNT_W'(DEPTH)) $display("FAIL full_count: got %0d want %0d", count, DEPTH); else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else n_pass++;
        drive(1'b1, 32'hDEAD_BEEF, 32'h5000, 1'b0, 1'b0);
        n_total++;
        if (count !== CNT_W'(DEPTH)) $display("FAIL fifth_ignored: count %0d want %0d", count, DEPTH); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            w = exp_q[0][31:0];
            n_total++;
            if (out_instr !== w || out_pc !== exp_q[0][63:32])
                $display("FAIL drain_head%0d: got %h@%h want %h@%h", i, out_instr, out_pc, w, exp_q[0][63:32]);
            else n_pass++;
            n_total++;
            if (op !== w[31:26] || func !== w[5:0] || rd !== w[15:11] || shamt !== w[10:6] || jidx26 !== w[25:0])
                $display("FAIL drain_fields%0d: op=%h func=%h rd=%0d shamt=%0d want from %h", i, op, func, rd, shamt, w);
            else n_pass++;
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        n_total++;
        if (count !== '0 || out_valid !== 1'b0) $display("FAIL drained: count=%0d valid=%b want 0/0", count, out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, $urandom, 32'h6000 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'hCAFE_0001, 32'h6100, 1'b1, 1'b0);
        n_total++;
        if (count !== CNT_W'(3)) $display("FAIL full_push_pop_count: got %0d want 3", count); else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (out_instr !== exp_q[0][31:0] || out_pc !== exp_q[0][63:32])
                $display("FAIL wrap_head%0d: got %h@%h want %h@%h", i, out_instr, out_pc, exp_q[0][31:0], exp_q[0][63:32]);
            else n_pass++;
            drive(1'b1, $urandom, 32'h7000 + 32'(4 * i), 1'b1, 1'b0);
            n_total++;
            if (count !== CNT_W'(2)) $display("FAIL wrap_count%0d: got %0d want 2", i, count); else n_pass++;
        end
        while (exp_q.size() != 0) begin
            n_total++;
            if (out_instr !== exp_q[0][31:0]) $display("FAIL wrap_drain: got %h want %h", out_instr, exp_q[0][31:0]);
            else n_pass++;
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++)
            drive(1'b1, $urandom, 32'h8000 + 32'(4 * i), 1'b0, 1'b0);
        n_total++;
        if (count !== CNT_W'(3)) $display("FAIL preflush_count: got %0d want 3", count); else n_pass++;
        drive(1'b1, 32'hBAD0_BAD0, 32'h8100, 1'b1, 1'b1);
        n_total++;
        if (count !== '0 || out_valid !== 1'b0 || out_instr !== 32'h0)
            $display("FAIL flush_state: count=%0d valid=%b instr=%h want 0/0/0", count, out_valid, out_instr);
        else n_pass++;
        drive(1'b1, 32'h0123_4567, 32'h8200, 1'b0, 1'b0);
        n_total++;
        if (count !== CNT_W'(1) || out_instr !== exp_q[0][31:0] || out_pc !== exp_q[0][63:32])
            $display("FAIL post_flush_head: count=%0d got %h@%h want 1 %h@%h", count, out_instr, out_pc,
                     exp_q[0][31:0], exp_q[0][63:32]);
        else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

`ifdef IFQ_IMM_EXT_EN
    task automatic test_imm_ext();
        logic [31:0] want [4];
        want[0] = 32'h0000_FFF0;
        want[1] = 32'hFFFF_FFF0;
        want[2] = 32'hFFF0_0000;
        want[3] = 32'h0000_0000;
        drive(1'b1, 32'h2001_FFF0, 32'h9000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ext_op = 2'(i);
            #1;
            n_total++;
            if (imm_ext !== want[i]) $display("FAIL imm_ext_op%0d: got %h want %h", i, imm_ext, want[i]);
            else n_pass++;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        ext_op = 2'b01;
        #1;
        n_total++;
        if (imm_ext !== 32'h0) $display("FAIL imm_ext_empty: got %h want 0", imm_ext); else n_pass++;
    endtask
`endif

    initial begin
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_push();
        test_fill_and_drain();
        test_back_to_back();
        test_flush();
`ifdef IFQ_IMM_EXT_EN
        test_imm_ext();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
